// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the decoder
// that drives its op field.
package mdu_pkg;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] code);
    return code[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: shift-add multiply and restoring
// divide on unsigned magnitudes, with sign correction in a final FIXUP cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e       state;
  logic [1:0]       op_q;
  logic             sa, sb, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b, a_q;
  logic [2*WIDTH-1:0] acc;  // multiply: {partial, multiplier}; divide: low half = dividend/quotient
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
  always_comb begin
    abs_a     = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
    abs_b     = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    div_ok    = ~div_diff[WIDTH+1];
    prod_fix  = (sa ^ sb) ? -acc : acc;
    quot_fix  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  assign busy = (state != IDLE);

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= MDU_MULT;
      sa       <= 1'b0;
      sb       <= 1'b0;
      b_zero   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_q      <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q     <= op;
            sa       <= op_is_signed(op) & a[WIDTH-1];
            sb       <= op_is_signed(op) & b[WIDTH-1];
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            a_q      <= a;
            b_zero   <= (b == '0);
            acc      <= op_is_div(op) ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            rem      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (op_is_div(op_q)) begin
            rem             <= div_ok ? div_diff[WIDTH:0] : div_shift;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MDU_ITERS - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (!op_is_div(op_q)) begin
            {hi, lo} <= prod_fix;
          end else if (b_zero) begin
            lo       <= '1;
            hi       <= a_q;
            div_zero <= 1'b1;
          end else begin
            lo <= quot_fix;
            hi <= rem_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, latency,
// handshake, MTHI/MTLO and mid-operation reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on abort).
  // lat counts edges after the accept edge; bc counts cycles with busy high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke_at, input int rst_at,
                        output int lat, output int bc, output logic dz1, output logic aborted);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0;
    lat = 0; bc = 0; dz1 = div_zero; aborted = 1'b0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      if (lat == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (lat == poke_at) begin
        start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd5;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
  endtask

  int   lat, bc, done_seen;
  logic dz1, aborted;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, lat, bc, dz1, aborted);
    check("multu_lat", lat, 33);
    check("multu_busy_cycles", bc, 33);
    check("multu_busy_at_done", busy, 0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    // issued in the done cycle of the previous op
    run_op(MDU_MULT, 32'hFFFFFFF9, 32'd6, -1, -1, lat, bc, dz1, aborted);
    check("b2b_mult_lat", lat, 33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFD6);

    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, -1, -1, lat, bc, dz1, aborted);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, lat, bc, dz1, aborted);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h0);
    check("ovf_dz", div_zero, 0);

    run_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, -1, -1, lat, bc, dz1, aborted);
    check("div_negb_lo", lo, 32'hFFFFFFFD);
    check("div_negb_hi", hi, 32'd1);

    run_op(MDU_DIVU, 32'd100, 32'd0, -1, -1, lat, bc, dz1, aborted);
    check("dz_lat", lat, 33);
    check("dz_lo", lo, 32'hFFFFFFFF);
    check("dz_hi", hi, 32'd100);
    check("dz_flag", div_zero, 1);

    run_op(MDU_MULTU, 32'd3, 32'd4, -1, -1, lat, bc, dz1, aborted);
    check("dz_clear_on_start", dz1, 0);
    check("multu_small_lo", lo, 32'd12);
    check("multu_small_hi", hi, 32'd0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    run_op(MDU_MULT, 32'h80000000, 32'h80000000, -1, -1, lat, bc, dz1, aborted);
    check("mult_min_hi", hi, 32'h40000000);
    check("mult_min_lo", lo, 32'h0);
    @(negedge clk);

    run_op(MDU_DIVU, 32'd1000, 32'd7, 10, -1, lat, bc, dz1, aborted);
    check("poke_lat", lat, 33);
    check("poke_lo", lo, 32'd142);
    check("poke_hi", hi, 32'd6);
    @(negedge clk);
    check("poke_no_restart", busy, 0);

    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'd142);
    lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, -1, 15, lat, bc, dz1, aborted);
    check("rst_mid_aborted", aborted, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("rst_mid_no_done", done_seen, 0);

    run_op(MDU_MULTU, 32'd9, 32'd9, -1, -1, lat, bc, dz1, aborted);
    check("post_rst_lat", lat, 33);
    check("post_rst_lo", lo, 32'd81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
